// File: rtl/lsu_mem_port.sv
// LSU-side responder: serialises one load/store into byte accesses on a synchronous byte-wide RAM.
// Optional feature: define IO_BUFFER_FULL_EN to stall I/O-space stores while the UART buffer is full.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  enable_in,
  input  logic                  rw_flag_in,
  input  logic [1:0]            size_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rollback_in,
  output logic                  end_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
`ifdef IO_BUFFER_FULL_EN
  ,
  input  logic                  io_buffer_full
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              len_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2:0]              issue_q;
  logic [1:0]              cap_q;
  logic [1:0]              a_idx_q;
  logic [1:0]              d_idx_q;
  logic                    d_vld_q;
  logic [2:0]              wr_idx_q;
  logic                    end_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [7:0]              mem_dout_q;
  logic [ADDR_WIDTH-1:0]   mem_a_q;
  logic                    mem_wr_q;

  logic [1:0]              len_d;
  logic                    io_hold_acc;
  logic                    io_hold_wr;

  always_comb begin
    case (size_in)
      2'd0:    len_d = 2'd0;
      2'd1:    len_d = 2'd1;
      default: len_d = 2'd3;
    endcase
  end

`ifdef IO_BUFFER_FULL_EN
  assign io_hold_acc = (address_in[17:16] == 2'b11) && io_buffer_full;
  assign io_hold_wr  = (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  assign io_hold_acc = 1'b0;
  assign io_hold_wr  = 1'b0;
`endif

  // d_* tracks which byte mem_din carries this cycle: the RAM keeps sampling mem_a even while frozen.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      data_q     <= '0;
      issue_q    <= '0;
      cap_q      <= '0;
      a_idx_q    <= '0;
      d_idx_q    <= '0;
      d_vld_q    <= 1'b0;
      wr_idx_q   <= '0;
      end_q      <= 1'b1;
      data_out_q <= '0;
      mem_dout_q <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (enable_in && !rollback_in) begin
            addr_q  <= address_in;
            len_q   <= len_d;
            data_q  <= data_in;
            end_q   <= 1'b0;
            mem_a_q <= address_in;
            if (rw_flag_in) begin
              state_q    <= S_READ;
              data_out_q <= '0;
              issue_q    <= 3'd1;
              cap_q      <= 2'd0;
              a_idx_q    <= 2'd0;
              d_vld_q    <= 1'b0;
            end else begin
              state_q <= S_WRITE;
              if (io_hold_acc) begin
                mem_wr_q <= 1'b0;
                wr_idx_q <= 3'd0;
              end else begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= data_in[7:0];
                wr_idx_q   <= 3'd1;
              end
            end
          end
        end
        S_READ: begin
          if (rollback_in) begin
            state_q <= S_IDLE;
            end_q   <= 1'b1;
          end else begin
            d_vld_q <= 1'b1;
            d_idx_q <= a_idx_q;
            if (d_vld_q && (d_idx_q == cap_q)) begin
              data_out_q[{cap_q, 3'b000} +: 8] <= mem_din;
              cap_q <= cap_q + 2'd1;
              if (cap_q == len_q) begin
                state_q <= S_DONE;
                end_q   <= 1'b1;
              end
            end
            if (issue_q <= {1'b0, len_q}) begin
              mem_a_q <= addr_q + {{(ADDR_WIDTH-3){1'b0}}, issue_q};
              a_idx_q <= issue_q[1:0];
              issue_q <= issue_q + 3'd1;
            end
          end
        end
        S_WRITE: begin
          if (wr_idx_q <= {1'b0, len_q}) begin
            if (io_hold_wr) begin
              mem_wr_q <= 1'b0;
            end else begin
              mem_wr_q   <= 1'b1;
              mem_a_q    <= addr_q + {{(ADDR_WIDTH-3){1'b0}}, wr_idx_q};
              mem_dout_q <= data_q[{wr_idx_q[1:0], 3'b000} +: 8];
              wr_idx_q   <= wr_idx_q + 3'd1;
            end
          end else begin
            mem_wr_q <= 1'b0;
            state_q  <= S_DONE;
            end_q    <= 1'b1;
          end
        end
        S_DONE: begin
          if (rollback_in || !enable_in) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end else if (state_q == S_READ) begin
      issue_q <= {1'b0, cap_q};
      d_vld_q <= 1'b1;
      d_idx_q <= a_idx_q;
    end
  end

  assign end_out  = end_q;
  assign data_out = data_out_q;
  assign mem_dout = mem_dout_q;
  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q & rdy_in;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Responder end of the LSU-to-memory request interface. Accepts one load or store at a time from the LSU (address, size, store data), serialises it into single-byte accesses on the external byte-wide RAM bus (synchronous read, one-cycle read latency), and returns the assembled little-endian word with a completion handshake. It sits between the LSU and the top-level RAM pins. Sign and zero extension stay in the LSU; this block returns raw bytes.

## Interface
- ADDR_WIDTH, 32, byte address width on both sides
- DATA_WIDTH, 32, request/response data width; fixed at 4 bytes
- clk_in  input  1  clock; all state on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes the block
- enable_in  input  1  LSU request valid, level; held until end_out returns high
- rw_flag_in  input  1  1 = read, 0 = write
- size_in  input  2  byte count minus one: 0 = 1 B, 1 = 2 B, 3 = 4 B (2 treated as 4 B)
- address_in  input  ADDR_WIDTH  start byte address
- data_in  input  DATA_WIDTH  store data, low bytes used
- rollback_in  input  1  ROB flush
- end_out  output  1  high = idle or done; low = request in flight
- data_out  output  DATA_WIDTH  read result, zero-extended
- mem_din  input  8  RAM read byte, valid one cycle after address
- mem_dout  output  8  RAM write byte
- mem_a  output  ADDR_WIDTH  RAM byte address
- mem_wr  output  1  RAM write strobe, 1 = write
- io_buffer_full  input  1  UART buffer full; present only with IO_BUFFER_FULL_EN

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset values: end_out=1, data_out=0, mem_a=0, mem_dout=0, mem_wr=0, state IDLE, counters 0.
- IDLE: when enable_in=1, latch address, size, rw and data; go to READ or WRITE; end_out drops the next cycle.
- READ: issue index i and capture index c, both 0..n-1. mem_a=addr+i for each issued byte. The byte from mem_din is captured at the cycle after issue into data_out[8c+7:8c]. Bytes above n are cleared at acceptance. After the last capture, go to DONE.
- WRITE: for each k in 0..n-1: mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k]. After the last byte, go to DONE with mem_wr=0.
- DONE: end_out=1 and data_out held. Return to IDLE only after enable_in has been sampled low. A still-high enable_in never starts a second access.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH.
- rollback_in=1 during READ or DONE:
  - Abort and go to IDLE; end_out=1 next cycle.
  - data_out is not updated further.
  - No further RAM reads are issued.
- rollback_in=1 during WRITE: ignored. The committed store completes all bytes.
- rollback_in=1 and enable_in=1 both in IDLE: the request is not accepted.
- rdy_in=0:
  - No state, counter or output register changes.
  - mem_wr is forced 0 combinationally.
  - In READ, the issue index is reset to the capture index, so the in-flight byte is re-fetched when rdy_in returns.
- Asynchronous reset mid-access aborts immediately. A partial store may remain in RAM.

## Timing
- Cycle 0: request sampled in IDLE.
- Read of n bytes:
  - mem_a valid cycles 1..n.
  - Captures at cycles 2..n+1.
  - end_out low cycles 1..n+1; high with data_out valid from cycle n+2.
  - Latency 1 B = 3 cycles, 4 B = 6 cycles.
- Write of n bytes: mem_wr high cycles 1..n; end_out high from cycle n+1.
- Back-to-back requests: at least one cycle with enable_in low between them.
- Each cycle with rdy_in low adds one cycle, plus one re-fetch cycle if a read byte was in flight.

## Configuration
- IO_BUFFER_FULL_EN defined:
  - The io_buffer_full port exists.
  - A WRITE whose address has address_in[17:16]==2'b11 (I/O space, 0x30000 and up) issues no byte while io_buffer_full=1. It stays in WRITE with mem_wr=0 and proceeds when it returns low.
  - Non-I/O writes and all reads are unaffected.
- Not defined: the port is absent and I/O writes issue without waiting.

## Test plan
- Reset with rst_in=0 mid-write, then release -> end_out=1, mem_wr=0, mem_a=0.
- LW at 0x1000, RAM bytes 0x78,0x56,0x34,0x12 -> mem_a 0x1000..0x1003 on cycles 1-4; end_out=1 at cycle 6 with data_out=0x12345678.
- SH of data_in=0xDEADBEEF at 0x2002 -> mem_wr=1 at 0x2002/0xEF and 0x2003/0xBE; end_out=1 at cycle 3; data_out unchanged.
- LB at 0x0FFF with rdy_in low during cycle 2 -> address re-issued; data_out=0x000000XX one cycle later than nominal; enable_in held high in DONE -> no second access.
- LW with rollback_in pulsed at cycle 3 -> IDLE, end_out=1 at cycle 4, no mem_a change after cycle 3. The same pulse during SW -> all 4 bytes written.
- IO_BUFFER_FULL_EN: SB to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0, then a single write; SB to 0x100 is not delayed.
